// File: rtl/int_issue_queue.sv
// Integer issue queue: buffers renamed uops, wakes source operands from writeback
// broadcasts, and issues the oldest ready uop into the ALU's input register.
package int_issue_queue_pkg;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned SQN_W  = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ARCH_W = 5;

  typedef enum logic [5:0] {
    INT_ADD = 6'd0,
    INT_SUB = 6'd1,
    INT_AND = 6'd2,
    INT_OR  = 6'd3,
    INT_XOR = 6'd4,
    INT_SLL = 6'd5,
    INT_SRL = 6'd6,
    INT_BEQ = 6'd7
  } OPCode_INT;

  typedef struct packed {
    logic                        valid;
    OPCode_INT                   opcode;
    logic [1:0][TAG_W-1:0]       tag;
    logic [1:0]                  rdy;
    logic [1:0][DATA_W-1:0]      val;
    logic [DATA_W-1:0]           imm;
    logic [TAG_W-1:0]            tag_dst;
    logic [ARCH_W-1:0]           nm_dst;
    logic [SQN_W-1:0]            sqn;
  } iq_entry_t;
endpackage

module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int unsigned SIZE   = 8,
  parameter int unsigned NUM_WB = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          IN_uopValid,
  input  OPCode_INT                     IN_opcode,
  input  logic [1:0][TAG_W-1:0]         IN_srcTag,
  input  logic [1:0]                    IN_srcReady,
  input  logic [1:0][DATA_W-1:0]        IN_srcValue,
  input  logic [DATA_W-1:0]             IN_imm,
  input  logic [TAG_W-1:0]              IN_tagDst,
  input  logic [ARCH_W-1:0]             IN_nmDst,
  input  logic [SQN_W-1:0]              IN_sqN,
  output logic                          OUT_full,
  input  logic [NUM_WB-1:0]             IN_wbValid,
  input  logic [NUM_WB-1:0][TAG_W-1:0]  IN_wbTag,
  input  logic [NUM_WB-1:0][DATA_W-1:0] IN_wbResult,
  input  logic                          IN_wbStall,
  input  logic                          IN_branchTaken,
  input  logic [SQN_W-1:0]              IN_branchSqN,
  output logic                          OUT_valid,
  output logic [2:0][DATA_W-1:0]        OUT_operands,
  output OPCode_INT                     OUT_opcode,
  output logic [TAG_W-1:0]              OUT_tagDst,
  output logic [ARCH_W-1:0]             OUT_nmDst,
  output logic [SQN_W-1:0]              OUT_sqN
);
  localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  iq_entry_t [SIZE-1:0]    entries_q, entries_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_full_q, out_full_d;
  logic [2:0][DATA_W-1:0]  out_operands_q, out_operands_d;
  OPCode_INT               out_opcode_q, out_opcode_d;
  logic [TAG_W-1:0]        out_tag_dst_q, out_tag_dst_d;
  logic [ARCH_W-1:0]       out_nm_dst_q, out_nm_dst_d;
  logic [SQN_W-1:0]        out_sqn_q, out_sqn_d;

  logic                    flush, advance, dispatch;
  logic                    sel_found, free_found;
  logic [IDX_W-1:0]        sel_idx, free_idx;
  iq_entry_t               new_entry;

  // a is older than b when the wrapped 6-bit difference is negative
  function automatic logic is_older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] diff;
    diff = a - b;
    return diff[SQN_W-1];
  endfunction

  always_comb begin
    entries_d      = entries_q;
    out_valid_d    = out_valid_q;
    out_operands_d = out_operands_q;
    out_opcode_d   = out_opcode_q;
    out_tag_dst_d  = out_tag_dst_q;
    out_nm_dst_d   = out_nm_dst_q;
    out_sqn_d      = out_sqn_q;
    out_full_d     = 1'b1;
    sel_found      = 1'b0;
    sel_idx        = '0;
    free_found     = 1'b0;
    free_idx       = '0;
    new_entry      = '0;
    flush          = IN_branchTaken;
    advance        = !out_valid_q || !IN_wbStall;
    dispatch       = IN_uopValid && !out_full_q && !flush;

    // Oldest ready entry; wrong-path entries are excluded during a flush
    for (int i = 0; i < SIZE; i++) begin
      if (entries_q[i].valid && (&entries_q[i].rdy) &&
          !(flush && is_older(IN_branchSqN, entries_q[i].sqn)) &&
          (!sel_found || is_older(entries_q[i].sqn, entries_q[sel_idx].sqn))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end

    for (int i = SIZE - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end

    // Operand wakeup; descending scan lets the lowest matching bus win
    for (int i = 0; i < SIZE; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (!entries_q[i].rdy[s]) begin
          for (int w = int'(NUM_WB) - 1; w >= 0; w--) begin
            if (IN_wbValid[w] && IN_wbTag[w] == entries_q[i].tag[s]) begin
              entries_d[i].rdy[s] = 1'b1;
              entries_d[i].val[s] = IN_wbResult[w];
            end
          end
        end
      end
    end

    if (advance) begin
      out_valid_d = sel_found;
      if (sel_found) begin
        out_operands_d = {entries_q[sel_idx].imm, entries_q[sel_idx].val};
        out_opcode_d   = entries_q[sel_idx].opcode;
        out_tag_dst_d  = entries_q[sel_idx].tag_dst;
        out_nm_dst_d   = entries_q[sel_idx].nm_dst;
        out_sqn_d      = entries_q[sel_idx].sqn;
        entries_d[sel_idx].valid = 1'b0;
      end
    end

    // A wrong-path uop in the output register is dropped even while stalled
    if (flush) begin
      if (out_valid_q && is_older(IN_branchSqN, out_sqn_q)) begin
        out_valid_d = 1'b0;
      end
      for (int i = 0; i < SIZE; i++) begin
        if (is_older(IN_branchSqN, entries_q[i].sqn)) begin
          entries_d[i].valid = 1'b0;
        end
      end
    end

    new_entry.valid   = 1'b1;
    new_entry.opcode  = IN_opcode;
    new_entry.tag     = IN_srcTag;
    new_entry.rdy     = IN_srcReady;
    new_entry.val     = IN_srcValue;
    new_entry.imm     = IN_imm;
    new_entry.tag_dst = IN_tagDst;
    new_entry.nm_dst  = IN_nmDst;
    new_entry.sqn     = IN_sqN;
    for (int s = 0; s < 2; s++) begin
      if (!IN_srcReady[s]) begin
        for (int w = int'(NUM_WB) - 1; w >= 0; w--) begin
          if (IN_wbValid[w] && IN_wbTag[w] == IN_srcTag[s]) begin
            new_entry.rdy[s] = 1'b1;
            new_entry.val[s] = IN_wbResult[w];
          end
        end
      end
    end
    if (dispatch && free_found) begin
      entries_d[free_idx] = new_entry;
    end

    for (int i = 0; i < SIZE; i++) begin
      if (!entries_d[i].valid) begin
        out_full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q      <= '0;
      out_valid_q    <= 1'b0;
      out_full_q     <= 1'b0;
      out_operands_q <= '0;
      out_opcode_q   <= INT_ADD;
      out_tag_dst_q  <= '0;
      out_nm_dst_q   <= '0;
      out_sqn_q      <= '0;
    end else if (en) begin
      entries_q      <= entries_d;
      out_valid_q    <= out_valid_d;
      out_full_q     <= out_full_d;
      out_operands_q <= out_operands_d;
      out_opcode_q   <= out_opcode_d;
      out_tag_dst_q  <= out_tag_dst_d;
      out_nm_dst_q   <= out_nm_dst_d;
      out_sqn_q      <= out_sqn_d;
    end
  end

  assign OUT_full     = out_full_q;
  assign OUT_valid    = out_valid_q;
  assign OUT_operands = out_operands_q;
  assign OUT_opcode   = out_opcode_q;
  assign OUT_tagDst   = out_tag_dst_q;
  assign OUT_nmDst    = out_nm_dst_q;
  assign OUT_sqN      = out_sqn_q;
endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the issue rules.
module tb_int_issue_queue;
  import int_issue_queue_pkg::*;

  localparam int unsigned SIZE   = 8;
  localparam int unsigned NUM_WB = 2;

  logic                    clk = 1'b0;
  logic                    rst, en, IN_uopValid;
  OPCode_INT               IN_opcode;
  logic [1:0][5:0]         IN_srcTag;
  logic [1:0]              IN_srcReady;
  logic [1:0][31:0]        IN_srcValue;
  logic [31:0]             IN_imm;
  logic [5:0]              IN_tagDst;
  logic [4:0]              IN_nmDst;
  logic [5:0]              IN_sqN;
  logic                    OUT_full;
  logic [NUM_WB-1:0]       IN_wbValid;
  logic [NUM_WB-1:0][5:0]  IN_wbTag;
  logic [NUM_WB-1:0][31:0] IN_wbResult;
  logic                    IN_wbStall, IN_branchTaken;
  logic [5:0]              IN_branchSqN;
  logic                    OUT_valid;
  logic [2:0][31:0]        OUT_operands;
  OPCode_INT               OUT_opcode;
  logic [5:0]              OUT_tagDst;
  logic [4:0]              OUT_nmDst;
  logic [5:0]              OUT_sqN;

  always #5 clk = ~clk;

  int_issue_queue #(.SIZE(SIZE), .NUM_WB(NUM_WB)) dut (
    .clk(clk), .rst(rst), .en(en), .IN_uopValid(IN_uopValid), .IN_opcode(IN_opcode),
    .IN_srcTag(IN_srcTag), .IN_srcReady(IN_srcReady), .IN_srcValue(IN_srcValue),
    .IN_imm(IN_imm), .IN_tagDst(IN_tagDst), .IN_nmDst(IN_nmDst), .IN_sqN(IN_sqN),
    .OUT_full(OUT_full), .IN_wbValid(IN_wbValid), .IN_wbTag(IN_wbTag),
    .IN_wbResult(IN_wbResult), .IN_wbStall(IN_wbStall), .IN_branchTaken(IN_branchTaken),
    .IN_branchSqN(IN_branchSqN), .OUT_valid(OUT_valid), .OUT_operands(OUT_operands),
    .OUT_opcode(OUT_opcode), .OUT_tagDst(OUT_tagDst), .OUT_nmDst(OUT_nmDst), .OUT_sqN(OUT_sqN)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: unordered pool of waiting uops plus the presented uop
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  tag [2];
    bit          rdy [2];
    logic [31:0] v   [2];
    logic [31:0] imm;
    logic [5:0]  tdst;
    logic [4:0]  ndst;
    logic [5:0]  sqn;
  } mu_t;

  mu_t        mq[$];
  mu_t        m_out;
  bit         m_ov = 0, m_full = 0, m_accepted = 0, m_flushed = 0;
  logic [5:0] next_sqn = '0;

  function automatic bit m_older(input logic [5:0] a, input logic [5:0] b);
    int d;
    d = (int'(a) - int'(b)) & 63;
    return d >= 32;
  endfunction

  function automatic void m_wake(inout mu_t u);
    for (int s = 0; s < 2; s++) begin
      if (!u.rdy[s]) begin
        for (int w = 0; w < int'(NUM_WB); w++) begin
          if (IN_wbValid[w] && IN_wbTag[w] == u.tag[s]) begin
            u.rdy[s] = 1;
            u.v[s]   = IN_wbResult[w];
            break;
          end
        end
      end
    end
  endfunction

  function automatic void model_step();
    int  sel;
    bit  adv, fl, take, nov;
    mu_t nout, u, tmp;
    m_accepted = 0;
    m_flushed  = 0;
    if (rst) begin
      mq.delete();
      m_ov   = 0;
      m_full = 0;
      return;
    end
    if (!en) return;
    fl   = IN_branchTaken;
    adv  = !m_ov || !IN_wbStall;
    take = IN_uopValid && !m_full && !fl;
    sel  = -1;
    for (int k = 0; k < mq.size(); k++)
      if (mq[k].rdy[0] && mq[k].rdy[1] && !(fl && m_older(IN_branchSqN, mq[k].sqn)))
        if (sel < 0 || m_older(mq[k].sqn, mq[sel].sqn)) sel = k;
    nov  = m_ov;
    nout = m_out;
    if (adv) begin
      nov = (sel >= 0);
      if (sel >= 0) begin
        nout = mq[sel];
        mq.delete(sel);
      end
    end
    if (fl && m_ov && m_older(IN_branchSqN, m_out.sqn)) nov = 0;
    if (fl)
      for (int k = mq.size() - 1; k >= 0; k--)
        if (m_older(IN_branchSqN, mq[k].sqn)) mq.delete(k);
    for (int k = 0; k < mq.size(); k++) begin
      tmp = mq[k];
      m_wake(tmp);
      mq[k] = tmp;
    end
    if (take) begin
      u.op   = IN_opcode;
      for (int s = 0; s < 2; s++) begin
        u.tag[s] = IN_srcTag[s];
        u.rdy[s] = IN_srcReady[s];
        u.v[s]   = IN_srcValue[s];
      end
      u.imm  = IN_imm;
      u.tdst = IN_tagDst;
      u.ndst = IN_nmDst;
      u.sqn  = IN_sqN;
      m_wake(u);
      mq.push_back(u);
    end
    m_full     = (mq.size() == int'(SIZE));
    m_ov       = nov;
    m_out      = nout;
    m_accepted = take;
    m_flushed  = fl;
  endfunction

  task automatic compare_model();
    check_eq("out_valid", 64'(OUT_valid), 64'(m_ov));
    check_eq("out_full", 64'(OUT_full), 64'(m_full));
    if (m_ov) begin
      check_eq("opcode", 64'(OUT_opcode), 64'(m_out.op));
      check_eq("src0", 64'(OUT_operands[0]), 64'(m_out.v[0]));
      check_eq("src1", 64'(OUT_operands[1]), 64'(m_out.v[1]));
      check_eq("imm", 64'(OUT_operands[2]), 64'(m_out.imm));
      check_eq("tag_dst", 64'(OUT_tagDst), 64'(m_out.tdst));
      check_eq("nm_dst", 64'(OUT_nmDst), 64'(m_out.ndst));
      check_eq("sqn", 64'(OUT_sqN), 64'(m_out.sqn));
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle();
    rst = 0; en = 1; IN_uopValid = 0; IN_opcode = INT_ADD;
    IN_srcTag = '0; IN_srcReady = '0; IN_srcValue = '0; IN_imm = '0;
    IN_tagDst = '0; IN_nmDst = '0; IN_sqN = '0;
    IN_wbValid = '0; IN_wbTag = '0; IN_wbResult = '0;
    IN_wbStall = 0; IN_branchTaken = 0; IN_branchSqN = '0;
  endtask

  task automatic set_uop(input OPCode_INT op, input logic [5:0] sqn, input logic r0,
                         input logic [5:0] t0, input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] imm);
    IN_uopValid = 1; IN_opcode = op; IN_sqN = sqn;
    IN_srcReady[0] = r0; IN_srcTag[0] = t0; IN_srcValue[0] = v0;
    IN_srcReady[1] = 1;  IN_srcTag[1] = '0; IN_srcValue[1] = v1;
    IN_imm = imm; IN_tagDst = sqn + 6'd32; IN_nmDst = sqn[4:0];
  endtask

  task automatic broadcast(input int bus, input logic [5:0] tag, input logic [31:0] val);
    IN_wbValid[bus] = 1; IN_wbTag[bus] = tag; IN_wbResult[bus] = val;
  endtask

  task automatic rand_inputs();
    logic [5:0] cand[$];
    int maxd;
    idle();
    foreach (mq[k]) cand.push_back(mq[k].sqn);
    if (m_ov) cand.push_back(m_out.sqn);
    maxd = 0;
    foreach (cand[k]) if (((int'(next_sqn) - int'(cand[k])) & 63) > maxd)
      maxd = (int'(next_sqn) - int'(cand[k])) & 63;
    en = ($urandom_range(0, 19) != 0);
    rst = ($urandom_range(0, 499) == 0);
    IN_uopValid = ($urandom_range(0, 2) != 0) && (maxd < 28);
    IN_opcode = OPCode_INT'(6'($urandom_range(0, 7)));
    for (int s = 0; s < 2; s++) begin
      IN_srcTag[s]   = 6'($urandom_range(0, 7));
      IN_srcReady[s] = 1'($urandom_range(0, 1));
      IN_srcValue[s] = $urandom;
    end
    IN_imm = $urandom; IN_tagDst = 6'($urandom); IN_nmDst = 5'($urandom); IN_sqN = next_sqn;
    for (int w = 0; w < int'(NUM_WB); w++) begin
      IN_wbValid[w]  = 1'($urandom_range(0, 1));
      IN_wbTag[w]    = 6'($urandom_range(0, 7));
      IN_wbResult[w] = $urandom;
    end
    IN_wbStall = ($urandom_range(0, 3) == 0);
    if (cand.size() > 0 && $urandom_range(0, 15) == 0) begin
      IN_branchTaken = 1;
      IN_branchSqN = cand[$urandom_range(0, cand.size() - 1)];
    end
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    check_eq("reset_valid", 64'(OUT_valid), 64'(0));
    check_eq("reset_full", 64'(OUT_full), 64'(0));

    // ADD with both sources ready
    idle(); set_uop(INT_ADD, 6'd3, 1, 6'd0, 32'd5, 32'd7, 32'd0); step();
    idle(); step();
    check_eq("add_valid", 64'(OUT_valid), 64'(1));
    check_eq("add_opcode", 64'(OUT_opcode), 64'(INT_ADD));
    check_eq("add_src0", 64'(OUT_operands[0]), 64'd5);
    check_eq("add_src1", 64'(OUT_operands[1]), 64'd7);
    check_eq("add_imm", 64'(OUT_operands[2]), 64'd0);
    check_eq("add_sqn", 64'(OUT_sqN), 64'd3);
    idle(); step();
    check_eq("add_drained", 64'(OUT_valid), 64'(0));

    // SUB waiting on tag 12 from bus 1
    idle(); set_uop(INT_SUB, 6'd4, 0, 6'd12, 32'd0, 32'd9, 32'd1); step();
    idle(); step();
    idle(); broadcast(1, 6'd12, 32'h100); step();
    check_eq("sub_not_yet", 64'(OUT_valid), 64'(0));
    idle(); step();
    check_eq("sub_valid", 64'(OUT_valid), 64'(1));
    check_eq("sub_src0", 64'(OUT_operands[0]), 64'h100);

    // Wrapped ages: 62 is older than 1
    idle(); set_uop(INT_OR, 6'd62, 0, 6'd30, 32'd0, 32'd1, 32'd2); step();
    idle(); set_uop(INT_OR, 6'd1, 0, 6'd30, 32'd0, 32'd3, 32'd4); step();
    idle(); broadcast(0, 6'd30, 32'hABC); step();
    idle(); step();
    check_eq("wrap_first", 64'(OUT_sqN), 64'd62);
    idle(); step();
    check_eq("wrap_second", 64'(OUT_sqN), 64'd1);

    // Stall holds the presented uop for three cycles
    idle(); set_uop(INT_XOR, 6'd9, 1, 6'd0, 32'd11, 32'd12, 32'd13); step();
    idle(); set_uop(INT_XOR, 6'd10, 1, 6'd0, 32'd21, 32'd22, 32'd23); step();
    for (int c = 0; c < 3; c++) begin
      idle(); IN_wbStall = 1; step();
      check_eq("stall_hold_sqn", 64'(OUT_sqN), 64'd9);
      check_eq("stall_hold_src0", 64'(OUT_operands[0]), 64'd11);
    end
    idle(); step();
    check_eq("stall_release", 64'(OUT_sqN), 64'd10);
    idle(); step();

    // Flush at sqN 10 kills presented 11 and pending 12, 13
    idle(); set_uop(INT_AND, 6'd11, 1, 6'd0, 32'd1, 32'd2, 32'd3); step();
    idle(); set_uop(INT_AND, 6'd10, 0, 6'd40, 32'd0, 32'd5, 32'd6); step();
    idle(); IN_wbStall = 1; set_uop(INT_AND, 6'd12, 0, 6'd40, 32'd0, 32'd7, 32'd8); step();
    idle(); IN_wbStall = 1; set_uop(INT_AND, 6'd13, 0, 6'd40, 32'd0, 32'd7, 32'd8); step();
    idle(); IN_wbStall = 1; IN_branchTaken = 1; IN_branchSqN = 6'd10; step();
    check_eq("flush_out_cleared", 64'(OUT_valid), 64'(0));
    idle(); broadcast(0, 6'd40, 32'h55); step();
    idle(); step();
    check_eq("flush_survivor", 64'(OUT_sqN), 64'd10);
    check_eq("flush_survivor_src0", 64'(OUT_operands[0]), 64'h55);
    idle(); step();
    check_eq("flush_young_gone", 64'(OUT_valid), 64'(0));

    // Fill all entries, overflow dispatch ignored, issue frees one
    for (int k = 0; k < int'(SIZE); k++) begin
      idle(); set_uop(INT_SLL, 6'(20 + k), 0, 6'(50 + k), 32'd0, 32'd1, 32'd2); step();
    end
    check_eq("full_set", 64'(OUT_full), 64'(1));
    idle(); set_uop(INT_SLL, 6'd28, 1, 6'd0, 32'd9, 32'd9, 32'd9); step();
    check_eq("full_hold", 64'(OUT_full), 64'(1));
    idle(); broadcast(0, 6'd50, 32'h77); step();
    check_eq("full_before_issue", 64'(OUT_full), 64'(1));
    idle(); step();
    check_eq("full_issue_sqn", 64'(OUT_sqN), 64'd20);
    check_eq("full_cleared", 64'(OUT_full), 64'(0));

    // Reset mid-operation with enable low
    idle(); rst = 1; en = 0; IN_wbStall = 1; step();
    check_eq("rst_mid_valid", 64'(OUT_valid), 64'(0));
    check_eq("rst_mid_full", 64'(OUT_full), 64'(0));

    next_sqn = '0;
    for (int n = 0; n < 4000; n++) begin
      rand_inputs();
      step();
      if (m_flushed) next_sqn = IN_branchSqN + 6'd1;
      else if (m_accepted) next_sqn = next_sqn + 6'd1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
